// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arbiter
// Purpose  : Shares the single asynchronous read port of the instruction
//            memory between the CPU fetch stage (F) and the debug/trace
//            readback port (D). One word access per cycle, combinational
//            grant, registered read data one cycle after acceptance.
//            Granted addresses are checked for alignment and range, and
//            cycles in which both sides request are counted (saturating).
//
// Build option:
//   IMEM_ARB_RR_EN  defined   -> round-robin between F and D on conflicts
//                   undefined -> fixed priority, F always wins conflicts
//
// Parameters:
//   DEPTH  number of 32-bit words in the instruction memory
//   CNT_W  width of the conflict counter
//
// Ports:
//   Clk             in   system clock, rising edge
//   Rst             in   synchronous reset, active low
//   F_Req/D_Req     in   read request from fetch / debug
//   F_Addr/D_Addr   in   byte address of the request (32)
//   F_Gnt/D_Gnt     out  request accepted this cycle (combinational)
//   F_Valid/D_Valid out  one-cycle response strobe
//   F_Data/D_Data   out  response data (32), held while Valid is low
//   F_Err/D_Err     out  response is an error, qualified by Valid
//   M_Address       out  word-aligned byte address to instruction memory
//   M_Instruction   in   asynchronous read data from instruction memory
//   Conflict_Count  out  saturating count of cycles with both requests high
//
// Revision : 1.0  initial release
// ============================================================================
module imem_port_arbiter #(
  parameter int DEPTH = 66,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  // fetch requester
  input  logic             F_Req,
  input  logic [31:0]      F_Addr,
  output logic             F_Gnt,
  output logic             F_Valid,
  output logic [31:0]      F_Data,
  output logic             F_Err,
  // debug requester
  input  logic             D_Req,
  input  logic [31:0]      D_Addr,
  output logic             D_Gnt,
  output logic             D_Valid,
  output logic [31:0]      D_Data,
  output logic             D_Err,
  // instruction memory port
  output logic [31:0]      M_Address,
  input  logic [31:0]      M_Instruction,
  // profiling
  output logic [CNT_W-1:0] Conflict_Count
);

  // Word-index bound compared against Addr[31:2].
  localparam logic [29:0]      DEPTH_IDX = 30'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic        conflict;
  logic        f_wins;
  logic        grant_f;
  logic        grant_d;
  logic        any_grant;
  logic [31:0] sel_addr;
  logic        misaligned;
  logic        out_of_range;
  logic        addr_err;
  logic [31:0] rd_word;

  assign conflict = F_Req && D_Req;

`ifdef IMEM_ARB_RR_EN
  // Side that won the most recent conflict cycle: 1 = D, 0 = F.
  // Reset to D so that F wins the first conflict after reset.
  logic last_d;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      last_d <= 1'b1;
    end else if (conflict) begin
      last_d <= grant_d;
    end
  end

  // Opposite of the last conflict winner.
  assign f_wins = last_d;
`else
  assign f_wins = 1'b1;
`endif

  // Grant selection. Nothing is granted while reset is held, so no access
  // can be started that the reset would then have to discard.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (Rst) begin
      if (conflict) begin
        if (f_wins) begin
          grant_f = 1'b1;
        end else begin
          grant_d = 1'b1;
        end
      end else begin
        grant_f = F_Req;
        grant_d = D_Req;
      end
    end
  end

  assign F_Gnt     = grant_f;
  assign D_Gnt     = grant_d;
  assign any_grant = grant_f || grant_d;

  // Address of the granted side; defaults to F when idle, which is harmless
  // because the error flag and memory address are both gated by any_grant.
  assign sel_addr     = grant_d ? D_Addr : F_Addr;
  assign misaligned   = (sel_addr[1:0] != 2'b00);
  assign out_of_range = (sel_addr[31:2] >= DEPTH_IDX);
  assign addr_err     = any_grant && (misaligned || out_of_range);

  // A faulting access never reaches the memory with its real address.
  assign M_Address = (any_grant && !addr_err) ? {sel_addr[31:2], 2'b00} : 32'h0;

  // The memory still returns a word for address 0 on error; suppress it.
  assign rd_word = addr_err ? 32'h0 : M_Instruction;

  // Response registers. Valid follows the grant of the previous cycle, so a
  // side granted on consecutive cycles sees Valid high on consecutive
  // cycles. Data and Err load only when their side was granted.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      F_Valid <= 1'b0;
      F_Data  <= 32'h0;
      F_Err   <= 1'b0;
      D_Valid <= 1'b0;
      D_Data  <= 32'h0;
      D_Err   <= 1'b0;
    end else begin
      F_Valid <= grant_f;
      D_Valid <= grant_d;
      if (grant_f) begin
        F_Data <= rd_word;
        F_Err  <= addr_err;
      end
      if (grant_d) begin
        D_Data <= rd_word;
        D_Err  <= addr_err;
      end
    end
  end

  // Saturating contention counter.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      Conflict_Count <= '0;
    end else if (conflict && (Conflict_Count != CNT_MAX)) begin
      Conflict_Count <= Conflict_Count + CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_port_arbiter
// Purpose  : Self-checking bench for imem_port_arbiter. A behavioural model
//            of the arbiter rules is compared with the DUT every cycle, and
//            directed scenarios add hand-computed literal expectations.
//            Honors IMEM_ARB_RR_EN the same way the design does.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_port_arbiter;

  localparam int DEPTH = 66;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             f_req, d_req;
  logic [31:0]      f_addr, d_addr;
  logic             f_gnt, f_valid, f_err;
  logic             d_gnt, d_valid, d_err;
  logic [31:0]      f_data, d_data;
  logic [31:0]      m_addr, m_instr;
  logic [CNT_W-1:0] cnt;

  always #5 clk = ~clk;

  imem_port_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Rst(rst),
    .F_Req(f_req), .F_Addr(f_addr), .F_Gnt(f_gnt), .F_Valid(f_valid),
    .F_Data(f_data), .F_Err(f_err),
    .D_Req(d_req), .D_Addr(d_addr), .D_Gnt(d_gnt), .D_Valid(d_valid),
    .D_Data(d_data), .D_Err(d_err),
    .M_Address(m_addr), .M_Instruction(m_instr),
    .Conflict_Count(cnt)
  );

  // Instruction memory: word i holds 0xC0DE0000 | i.
  function automatic logic [31:0] word_of(input longint idx);
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  assign m_instr = (longint'(m_addr) / 4 < DEPTH) ? word_of(longint'(m_addr) / 4) : 32'hDEAD_BEEF;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Behavioural model
  // ------------------------------------------------------------------------
  bit          started = 0;
  int          exp_cnt;
  bit          exp_last_d;      // last conflict winner was D
  logic        exp_fv, exp_dv, exp_fe, exp_de;
  logic [31:0] exp_fd, exp_dd;

  function automatic bit addr_bad(input logic [31:0] a);
    return (longint'(a) % 4 != 0) || (longint'(a) / 4 >= DEPTH);
  endfunction

  task automatic model_grant(input logic r, input logic fr, input logic dr,
                             input bit last_d, output logic gf, output logic gd);
    gf = 1'b0;
    gd = 1'b0;
    if (r) begin
      if (fr && dr) begin
`ifdef IMEM_ARB_RR_EN
        if (last_d) gf = 1'b1; else gd = 1'b1;
`else
        gf = 1'b1;
`endif
      end else begin
        gf = fr;
        gd = dr;
      end
    end
  endtask

  // Model state advances on the same edge as the DUT; inputs are stable here.
  always @(posedge clk) begin
    logic gf, gd;
    logic [31:0] a;
    if (!rst) begin
      started    = 1;
      exp_cnt    = 0;
      exp_last_d = 1;
      exp_fv = 0; exp_dv = 0; exp_fe = 0; exp_de = 0;
      exp_fd = 0; exp_dd = 0;
    end else if (started) begin
      model_grant(rst, f_req, d_req, exp_last_d, gf, gd);
      if (f_req && d_req) begin
        exp_cnt    = (exp_cnt + 1 > 2**CNT_W - 1) ? 2**CNT_W - 1 : exp_cnt + 1;
        exp_last_d = gd;
      end
      exp_fv = gf;
      exp_dv = gd;
      a = gd ? d_addr : f_addr;
      if (gf) begin
        exp_fe = addr_bad(a);
        exp_fd = exp_fe ? 32'h0 : word_of(longint'(a) / 4);
      end
      if (gd) begin
        exp_de = addr_bad(a);
        exp_dd = exp_de ? 32'h0 : word_of(longint'(a) / 4);
      end
    end
  end

  // Every-cycle comparison, mid-cycle.
  always @(negedge clk) begin
    logic gf, gd;
    logic [31:0] a, ma;
    if (started) begin
      model_grant(rst, f_req, d_req, exp_last_d, gf, gd);
      a  = gd ? d_addr : f_addr;
      ma = ((gf || gd) && !addr_bad(a)) ? (a & 32'hFFFF_FFFC) : 32'h0;
      chk("mdl_f_gnt",   32'(f_gnt),   32'(gf));
      chk("mdl_d_gnt",   32'(d_gnt),   32'(gd));
      chk("mdl_m_addr",  m_addr,       ma);
      chk("mdl_f_valid", 32'(f_valid), 32'(exp_fv));
      chk("mdl_d_valid", 32'(d_valid), 32'(exp_dv));
      chk("mdl_f_data",  f_data,       exp_fd);
      chk("mdl_d_data",  d_data,       exp_dd);
      chk("mdl_f_err",   32'(f_err),   32'(exp_fe));
      chk("mdl_d_err",   32'(d_err),   32'(exp_de));
      chk("mdl_cnt",     32'(cnt),     32'(exp_cnt));
    end
  end

  // ------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] gvec;
  logic [3:0] exp_pattern;

  initial begin
    rst = 1'b0; f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0;
`ifdef IMEM_ARB_RR_EN
    exp_pattern = 4'b0101;
`else
    exp_pattern = 4'b1111;
`endif
    step();
    step();

    // Requests are ignored while reset is held.
    f_req = 1'b1; f_addr = 32'h8;
    @(negedge clk);
    chk("rst_f_gnt",   32'(f_gnt),   32'h0);
    chk("rst_m_addr",  m_addr,       32'h0);
    chk("rst_f_valid", 32'(f_valid), 32'h0);
    chk("rst_f_data",  f_data,       32'h0);
    chk("rst_cnt",     32'(cnt),     32'h0);
    step();
    f_req = 1'b0; rst = 1'b1;
    step();

    // Single fetch of word 1.
    f_req = 1'b1; f_addr = 32'h4;
    @(negedge clk);
    chk("single_gnt",   32'(f_gnt), 32'h1);
    chk("single_maddr", m_addr,     32'h4);
    step();
    f_req = 1'b0;
    @(negedge clk);
    chk("single_valid",  32'(f_valid), 32'h1);
    chk("single_data",   f_data,       32'hC0DE_0001);
    chk("single_err",    32'(f_err),   32'h0);
    chk("single_dvalid", 32'(d_valid), 32'h0);
    step();

    // Back-to-back fetch of words 0, 1, 2.
    f_req = 1'b1; f_addr = 32'h0;
    step();
    f_addr = 32'h4;
    @(negedge clk);
    chk("b2b_v0", 32'(f_valid), 32'h1);
    chk("b2b_d0", f_data,       32'hC0DE_0000);
    step();
    f_addr = 32'h8;
    @(negedge clk);
    chk("b2b_v1", 32'(f_valid), 32'h1);
    chk("b2b_d1", f_data,       32'hC0DE_0001);
    step();
    f_req = 1'b0;
    @(negedge clk);
    chk("b2b_v2", 32'(f_valid), 32'h1);
    chk("b2b_d2", f_data,       32'hC0DE_0002);
    step();

    // Four cycles of contention.
    f_req = 1'b1; d_req = 1'b1; f_addr = 32'h10; d_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gvec[i] = f_gnt;
      step();
    end
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("conflict_cnt",     32'(cnt),  32'd4);
    chk("conflict_pattern", 32'(gvec), 32'(exp_pattern));
    step();

    // Misaligned debug read.
    d_req = 1'b1; d_addr = 32'h6;
    @(negedge clk);
    chk("mis_gnt",   32'(d_gnt), 32'h1);
    chk("mis_maddr", m_addr,     32'h0);
    step();
    d_req = 1'b0;
    @(negedge clk);
    chk("mis_valid", 32'(d_valid), 32'h1);
    chk("mis_err",   32'(d_err),   32'h1);
    chk("mis_data",  d_data,       32'h0);
    step();

    // Out of range (index 66), then the last valid index (65).
    f_req = 1'b1; f_addr = 32'h108;
    @(negedge clk);
    chk("oor_maddr", m_addr, 32'h0);
    step();
    f_addr = 32'h104;
    @(negedge clk);
    chk("oor_valid",   32'(f_valid), 32'h1);
    chk("oor_err",     32'(f_err),   32'h1);
    chk("oor_data",    f_data,       32'h0);
    chk("edge_maddr",  m_addr,       32'h104);
    step();
    f_req = 1'b0;
    @(negedge clk);
    chk("edge_err",  32'(f_err), 32'h0);
    chk("edge_data", f_data,     32'hC0DE_0041);
    step();
    step();

    // Reset lands on the edge that would deliver an accepted fetch.
    f_req = 1'b1; f_addr = 32'h8;
    @(negedge clk);
    chk("rmid_gnt", 32'(f_gnt), 32'h1);
    #2 rst = 1'b0;
    step();
    f_req = 1'b0;
    @(negedge clk);
    chk("rmid_valid", 32'(f_valid), 32'h0);
    chk("rmid_cnt",   32'(cnt),     32'h0);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rmid_after_valid", 32'(f_valid), 32'h0);
    step();

    // Counter saturation: 20 conflict cycles with a 4-bit counter.
    f_req = 1'b1; d_req = 1'b1; f_addr = 32'hC; d_addr = 32'h3;
    repeat (20) step();
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("sat_cnt", 32'(cnt), 32'd15);
    step();

    // Back-to-back debug reads.
    d_req = 1'b1; d_addr = 32'h0;
    step();
    d_addr = 32'h4;
    step();
    d_req = 1'b0;
    @(negedge clk);
    chk("d_b2b_valid", 32'(d_valid), 32'h1);
    chk("d_b2b_data",  d_data,       32'hC0DE_0001);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Two-requester arbiter and response sequencer for the single asynchronous read port of the instruction memory. Shares that port between the CPU fetch stage (F) and the debug/trace readback port (D). Performs one word access per cycle and returns registered read data with a one-cycle latency. Checks alignment and range, and counts contention cycles for profiling.

## Interface
Parameters:
- DEPTH, 66: number of 32-bit words in the instruction memory; valid word index is 0..DEPTH-1.
- CNT_W, 16: width of the conflict counter.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Rst  in  1  reset; synchronous, active-low.
- F_Req  in  1  fetch requester asserts to request a read.
- F_Addr  in  32  fetch byte address.
- F_Gnt  out  1  fetch request accepted this cycle (combinational).
- F_Valid  out  1  fetch response valid, one-cycle pulse.
- F_Data  out  32  fetch read data.
- F_Err  out  1  fetch response is an error (qualified by F_Valid).
- D_Req, D_Addr, D_Gnt, D_Valid, D_Data, D_Err: same directions, widths and meanings for the debug requester.
- M_Address  out  32  byte address driven to instruction memory.
- M_Instruction  in  32  asynchronous read data from instruction memory.
- Conflict_Count  out  CNT_W  saturating count of cycles with F_Req and D_Req both high.

## Operation
- Handshake: a request is accepted in a cycle where Req && Gnt. Each requester holds Req and Addr stable until Gnt. Dropping Req before Gnt is legal and has no effect.
- Arbitration is combinational and happens every cycle:
  - Only one Req high: that requester is granted.
  - Both high: the winner is chosen per Configuration.
  - At most one Gnt is high per cycle.
- Address path:
  - M_Address = {granted Addr[31:2], 2'b00}.
  - With no grant, M_Address = 0.
- Error check on the granted address:
  - Error if Addr[1:0] != 0 (misaligned) or Addr[31:2] >= DEPTH (out of range).
  - On error: response Err=1, Data=0, and M_Address = 0.
- Response registers:
  - At the edge ending an accepted cycle, the granted side's Valid is set to 1.
  - Data captures M_Instruction, or 0 on error. Err captures the error flag.
  - The other side's Valid is cleared.
  - Valid is high for exactly one cycle per accepted request.
  - Data and Err hold their last value while Valid=0.
- Round-robin pointer `last`:
  - Records the side granted in the most recent conflict cycle.
  - Updates only in conflict cycles.
- Conflict counter:
  - Increments by 1 in every cycle where F_Req && D_Req.
  - Saturates at 2^CNT_W-1; never wraps.

## Timing
- Grant latency: 0 cycles, combinational from Req in the same cycle.
- Data latency: exactly 1 cycle after acceptance, Valid at the next rising edge.
- Throughput: 1 access per cycle total. A single requester holding Req continuously gets back-to-back grants with Valid high every cycle.
- Reset (Rst=0 at a rising edge):
  - F_Valid=D_Valid=0, F_Data=D_Data=0, F_Err=D_Err=0.
  - Conflict_Count=0, `last` = D (F wins the first conflict).
  - While Rst=0, F_Gnt=D_Gnt=0 and M_Address=0.
- Reset mid-operation: a request accepted in the cycle before reset asserts produces no Valid. The response is discarded and no pending state survives reset.
- Simultaneous events:
  - A conflict cycle both grants one side and increments the counter.
  - A new grant to the same side in the cycle its Valid is high is legal; Valid stays high into the next cycle with the new data.

## Configuration
- IMEM_ARB_RR_EN defined: in a conflict cycle, grant the side opposite to `last`, then set `last` to the winner. This alternates F, D, F, D under sustained contention.
- IMEM_ARB_RR_EN undefined: fixed priority, F always wins conflicts. `last` is not implemented. D is granted only in cycles where F_Req=0.
- The counter, error checking and latency are identical in both builds.

## Test plan
- Single fetch: F_Req=1, F_Addr=0x00000004 for 1 cycle -> F_Gnt=1 that cycle, M_Address=0x4. Next cycle: F_Valid=1, F_Data=memory word 1, F_Err=0, D_Valid=0.
- Back-to-back fetch: F_Req held high with F_Addr 0x0, 0x4, 0x8 over 3 cycles -> F_Valid high for 3 consecutive cycles with words 0, 1, 2 in order.
- Contention: F_Req=D_Req=1 for 4 cycles.
  - RR build: grants F, D, F, D.
  - Fixed build: F×4, D_Gnt=0.
  - Both builds: Conflict_Count=4.
- Errors:
  - D_Addr=0x00000006 (misaligned) -> D_Valid=1, D_Err=1, D_Data=0.
  - F_Addr=0x00000108 (index 66 >= DEPTH) -> F_Err=1, F_Data=0, M_Address=0.
- Reset mid-access: accept F_Req at 0x8, then assert Rst=0 at the next edge -> F_Valid=0, Conflict_Count=0, no response delivered after Rst returns to 1.
- Counter saturation with CNT_W=4: both Req high for 20 cycles -> Conflict_Count stops at 15.
